generic_fifo_sc_x: RTL and testbench
====================================

Name: generic_fifo_sc_x

Overview:
Parametrised single-clock synchronous FIFO. It is the next generation of the single-clock FIFO family, generalised in data width and depth. It adds a selectable first-word-fall-through (FWFT) read mode, programmable almost-full and almost-empty thresholds, an exact occupancy count, and sticky overflow and underflow error flags. It is used as the general buffering primitive between single-clock-domain producers and consumers.

Parameters:
DW, 8, data width in bits (1..256)
AW, 4, address width; depth = 2^AW words (AW >= 2)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
clr  in  1  synchronous clear, active-high
din  in  DW  write data
we  in  1  write request
re  in  1  read request
af_th  in  AW+1  almost-full threshold
ae_th  in  AW+1  almost-empty threshold
dout  out  DW  read data
full  out  1  count == 2^AW
empty  out  1  count == 0
almost_full  out  1  count >= af_th
almost_empty  out  1  count <= ae_th
cnt  out  AW+1  exact occupancy, 0..2^AW
level  out  2  occupancy quadrant
ovf  out  1  sticky overflow
unf  out  1  sticky underflow

Behaviour:
- Reset (rst=0, asynchronous assert; release is synchronous to clk, handled by the system):
  - Read and write pointers = 0; cnt = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - level = 0, ovf = 0, unf = 0, dout = 0.
  - Memory contents are not reset.
- clr=1 at an edge:
  - Has the same effect as reset at that edge.
  - Overrides we and re: no write or read is accepted in that cycle.
- Write acceptance: wacc = we & !full.
  - On wacc, mem[wp] <= din and wp increments modulo 2^AW.
- Read acceptance: racc = re & !empty.
  - On racc, rp increments modulo 2^AW.
- Count update at each edge:
  - wacc & !racc: cnt+1.
  - racc & !wacc: cnt-1.
  - Both or neither: cnt unchanged.
- Simultaneous read and write:
  - Accepted together whenever the FIFO is neither full nor empty.
  - When full, only the read is accepted. When empty, only the write is accepted. There is no write-through and no read-through.
- Flag timing: full, empty, almost_full, almost_empty and level are derived from registered cnt. They reflect every accepted operation one edge after it.
- Thresholds:
  - af_th and ae_th are compared live, with no registering.
  - af_th = 0 forces almost_full = 1.
  - ae_th >= 2^AW forces almost_empty = 1.
- level:
  - 3 when cnt == 2^AW.
  - Otherwise cnt[AW-1:AW-2], i.e. the 0-25%, 25-50%, 50-75% and 75-<100% quadrants.
- FWFT=0 read timing: dout is a register loaded with mem[rp] at the edge where racc = 1. It is valid after that edge and holds until the next racc.
- FWFT=1 read timing:
  - dout = mem[rp] continuously; it is valid whenever empty = 0.
  - A word written at edge N into an empty FIFO appears on dout, with empty = 0, after edge N.
  - racc advances dout to the next word after the edge.
  - When empty = 1, dout is don't-care.
- Error flags:
  - ovf is set at an edge with we & full.
  - unf is set at an edge with re & empty.
  - Both are sticky until clr or rst.
  - The dropped request has no other effect.
- Wrap-around: pointers wrap silently. Data order is preserved across any number of wraps.
- Reset mid-operation: asserting rst at any point returns all outputs to their reset values immediately, without waiting for a clock.

Test Plan:
1. DW=8, AW=4, FWFT=0: write 0x11, 0x22, 0x33, then read 3 times -> dout = 0x11, 0x22, 0x33, one per read edge; cnt goes 3, 2, 1, 0; empty = 1 after the third read.
2. Fill with 16 writes -> full = 1, cnt = 16, level = 3. A 17th write -> cnt stays 16, ovf = 1. Then pulse clr -> cnt = 0, empty = 1, ovf = 0.
3. Empty FIFO, re = 1 -> unf = 1, cnt stays 0, dout unchanged. Then write 0xA5 -> unf remains 1.
4. cnt = 8, we = re = 1 for 40 cycles with random data -> cnt stays 8 throughout; all 40 words read back in order across pointer wrap; no flags change.
5. af_th = 12, ae_th = 3; write 12 words -> almost_empty deasserts after the 4th write, almost_full asserts after the 12th. Then read 1 word -> almost_full deasserts.
6. FWFT=1: write 0x5A at edge N -> after edge N, empty = 0 and dout = 0x5A with no read issued. Then read -> empty = 1. Separately, assert rst mid-burst with cnt = 9 -> cnt = 0 and empty = 1 before the next clock edge.

Source files
------------

// File: rtl/generic_fifo_sc_x.sv
// Parametrised single-clock FIFO with optional first-word-fall-through read,
// live almost-full/almost-empty thresholds, exact occupancy and sticky error flags.
module generic_fifo_sc_x #(
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter int FWFT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [DW-1:0] din,
    input  logic          we,
    input  logic          re,
    input  logic [AW:0]   af_th,
    input  logic [AW:0]   ae_th,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   cnt,
    output logic [1:0]    level,
    output logic          ovf,
    output logic          unf
);

    localparam logic [AW:0]   DEPTH_C   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   ZERO_C    = {(AW+1){1'b0}};
    localparam logic [AW:0]   ONE_C     = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE_C = {{(AW-1){1'b0}}, 1'b1};

    // Occupancy quadrant; bit AW of the count is only set when completely full.
    function automatic logic [1:0] quadrant(input logic [AW:0] c);
        if (c[AW]) begin
            return 2'b11;
        end else begin
            return c[AW-1:AW-2];
        end
    endfunction

    logic [DW-1:0] mem_r [2**AW];
    logic [AW-1:0] wp_r;
    logic [AW-1:0] rp_r;
    logic [AW:0]   cnt_r;
    logic [AW:0]   cnt_nxt_s;
    logic          ovf_r;
    logic          unf_r;
    logic          full_s;
    logic          empty_s;
    logic          wacc_s;
    logic          racc_s;

    assign full_s  = (cnt_r == DEPTH_C);
    assign empty_s = (cnt_r == ZERO_C);
    // clr wins over both requests in its cycle.
    assign wacc_s  = we & ~full_s  & ~clr;
    assign racc_s  = re & ~empty_s & ~clr;

    // Next occupancy from the accepted write/read pair.
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({wacc_s, racc_s})
            2'b10:   cnt_nxt_s = cnt_r + ONE_C;
            2'b01:   cnt_nxt_s = cnt_r - ONE_C;
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wacc_s) begin
            mem_r[wp_r] <= din;
        end
    end

    // Pointers, occupancy count and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_r  <= {AW{1'b0}};
            rp_r  <= {AW{1'b0}};
            cnt_r <= ZERO_C;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else if (clr) begin
            wp_r  <= {AW{1'b0}};
            rp_r  <= {AW{1'b0}};
            cnt_r <= ZERO_C;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (wacc_s) begin
                wp_r <= wp_r + PTR_ONE_C;
            end
            if (racc_s) begin
                rp_r <= rp_r + PTR_ONE_C;
            end
            cnt_r <= cnt_nxt_s;
            if (we && full_s) begin
                ovf_r <= 1'b1;
            end
            if (re && empty_s) begin
                unf_r <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is presented directly; meaningless while empty.
            assign dout = mem_r[rp_r];
        end else begin : g_reg
            logic [DW-1:0] dout_r;

            // Registered read data, updated only on an accepted read.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dout_r <= {DW{1'b0}};
                end else if (clr) begin
                    dout_r <= {DW{1'b0}};
                end else if (racc_s) begin
                    dout_r <= mem_r[rp_r];
                end
            end

            assign dout = dout_r;
        end
    endgenerate

    assign cnt          = cnt_r;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (cnt_r >= af_th);
    assign almost_empty = (cnt_r <= ae_th);
    assign level        = quadrant(cnt_r);
    assign ovf          = ovf_r;
    assign unf          = unf_r;

endmodule

// File: tb/tb_generic_fifo_sc_x.sv
// Randomised and directed bench for generic_fifo_sc_x: a registered-read and a
// FWFT instance share stimulus and are compared against a queue-based model.
module tb_generic_fifo_sc_x;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] din = 8'h00;
    logic          we  = 1'b0;
    logic          re  = 1'b0;
    logic [AW:0]   af_th = 5'd8;
    logic [AW:0]   ae_th = 5'd2;

    logic [DW-1:0] dout0, dout1;
    logic          full0, full1, empty0, empty1;
    logic          af0, af1, ae0, ae1;
    logic [AW:0]   cnt0, cnt1;
    logic [1:0]    level0, level1;
    logic          ovf0, ovf1, unf0, unf1;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] q[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    logic [DW-1:0] m_dout0 = 8'h00;

    always #5 clk = ~clk;

    generic_fifo_sc_x #(.DW(DW), .AW(AW), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .re(re),
        .af_th(af_th), .ae_th(ae_th), .dout(dout0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .cnt(cnt0), .level(level0),
        .ovf(ovf0), .unf(unf0)
    );

    generic_fifo_sc_x #(.DW(DW), .AW(AW), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .re(re),
        .af_th(af_th), .ae_th(ae_th), .dout(dout1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .cnt(cnt1), .level(level1),
        .ovf(ovf1), .unf(unf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_dout0 = 8'h00;
    endtask

    // Reference behaviour for one rising edge, using the inputs applied before it.
    task automatic model_edge();
        bit is_full, is_empty;
        if (clr) begin
            model_reset();
        end else begin
            is_full  = (q.size() == DEPTH);
            is_empty = (q.size() == 0);
            if (we && is_full)  m_ovf = 1'b1;
            if (re && is_empty) m_unf = 1'b1;
            if (re && !is_empty) m_dout0 = q.pop_front();
            if (we && !is_full)  q.push_back(din);
        end
    endtask

    task automatic check_all();
        int n;
        int exp_level;
        n = q.size();
        exp_level = (n == DEPTH) ? 3 : (n / 4);
        chk("cnt0",   32'(cnt0),   32'(n));
        chk("cnt1",   32'(cnt1),   32'(n));
        chk("full0",  32'(full0),  32'(n == DEPTH));
        chk("full1",  32'(full1),  32'(n == DEPTH));
        chk("empty0", 32'(empty0), 32'(n == 0));
        chk("empty1", 32'(empty1), 32'(n == 0));
        chk("af0",    32'(af0),    32'(n >= int'(af_th)));
        chk("af1",    32'(af1),    32'(n >= int'(af_th)));
        chk("ae0",    32'(ae0),    32'(n <= int'(ae_th)));
        chk("ae1",    32'(ae1),    32'(n <= int'(ae_th)));
        chk("level0", 32'(level0), 32'(exp_level));
        chk("level1", 32'(level1), 32'(exp_level));
        chk("ovf0",   32'(ovf0),   32'(m_ovf));
        chk("ovf1",   32'(ovf1),   32'(m_ovf));
        chk("unf0",   32'(unf0),   32'(m_unf));
        chk("unf1",   32'(unf1),   32'(m_unf));
        chk("dout0",  32'(dout0),  32'(m_dout0));
        if (n != 0) begin
            chk("dout1", 32'(dout1), 32'(q[0]));
        end
    endtask

    task automatic tick(input logic w, input logic r, input logic [DW-1:0] d);
        we  = w;
        re  = r;
        din = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1'b1, 1'b1, 8'hEE);
        clr = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        chk("rst_dout0", 32'(dout0), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // 1: three writes then three reads in order
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, vals[i]);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 8'h00);
            chk("t1_dout", 32'(dout0), 32'(vals[i]));
            chk("t1_cnt",  32'(cnt0),  32'(2 - i));
        end
        chk("t1_empty", 32'(empty0), 32'h1);

        // 2: fill, overflow, clear
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b0, 8'($urandom));
        chk("t2_full",  32'(full0),  32'h1);
        chk("t2_level", 32'(level0), 32'h3);
        tick(1'b1, 1'b0, 8'hFF);
        chk("t2_cnt16", 32'(cnt0), 32'd16);
        chk("t2_ovf",   32'(ovf0), 32'h1);
        pulse_clr();
        chk("t2_clr_ovf", 32'(ovf0), 32'h0);
        chk("t2_clr_cnt", 32'(cnt0), 32'h0);

        // 3: underflow is sticky
        tick(1'b0, 1'b1, 8'h00);
        chk("t3_unf", 32'(unf0), 32'h1);
        tick(1'b1, 1'b0, 8'hA5);
        chk("t3_unf_sticky", 32'(unf1), 32'h1);
        pulse_clr();

        // 4: steady occupancy 8 with simultaneous traffic across wraps
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 1'b1, 8'($urandom));
            chk("t4_cnt", 32'(cnt0), 32'd8);
        end
        pulse_clr();

        // 5: thresholds
        af_th = 5'd12;
        ae_th = 5'd3;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1, 1'b0, 8'(i));
            chk("t5_ae", 32'(ae0), 32'(i <= 3));
            chk("t5_af", 32'(af0), 32'(i >= 12));
        end
        tick(1'b0, 1'b1, 8'h00);
        chk("t5_af_drop", 32'(af0), 32'h0);
        pulse_clr();

        // 6: FWFT fall-through and asynchronous reset mid-burst
        tick(1'b1, 1'b0, 8'h5A);
        chk("t6_empty", 32'(empty1), 32'h0);
        chk("t6_dout1", 32'(dout1), 32'h5A);
        tick(1'b0, 1'b1, 8'h00);
        chk("t6_empty_after", 32'(empty1), 32'h1);
        for (int i = 0; i < 9; i++) tick(1'b1, 1'b0, 8'($urandom));
        chk("t6_cnt9", 32'(cnt1), 32'd9);
        we = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_cnt",   32'(cnt1),   32'h0);
        chk("t6_rst_empty", 32'(empty1), 32'h1);
        check_all();
        @(negedge clk);
        rst = 1'b1;
        we  = 1'b0;

        // Random traffic with occasional clear and threshold changes
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) begin
                af_th = 5'($urandom_range(0, 31));
                ae_th = 5'($urandom_range(0, 31));
            end
            clr = ($urandom_range(0, 63) == 0);
            if (i < 200) begin
                tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), 8'($urandom));
            end else if (i < 400) begin
                tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0), 8'($urandom));
            end else begin
                tick(1'($urandom), 1'($urandom), 8'($urandom));
            end
            clr = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
